// File: rtl/intt_pkg.sv
// Shared constants, state type and per-lane decode helpers for the flat INTT controller.
package intt_pkg;

  localparam int unsigned D      = 8;
  localparam int unsigned STAGES = $clog2(D);
  localparam int unsigned SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned AW     = $clog2(D);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  // Butterfly group index of lane j at stage s; odd groups are the subtracting half.
  function automatic int unsigned lane_group(input int unsigned j, input logic [SW-1:0] s);
    return j >> (STAGES - 1 - 32'(s));
  endfunction

  function automatic logic sub_select(input int unsigned j, input logic [SW-1:0] s);
    int unsigned m;
    m = lane_group(j, s);
    return m[0];
  endfunction

  function automatic logic [AW-1:0] twiddle_index(input int unsigned j, input logic [SW-1:0] s);
    int unsigned m;
    m = lane_group(j, s);
    if (m[0]) return AW'((m + 1) / 2 + (32'd1 << s) - 1);
    return '0;
  endfunction

endpackage

// File: rtl/intt_stage_decode.sv
// Combinational stage-index decode into per-lane subtract selects and psi_inv addresses.
module intt_stage_decode
  import intt_pkg::*;
(
  input  logic [SW-1:0]   stage,
  output logic [D-1:0]    sub,
  output logic [D*AW-1:0] twiddle_addr
);

  for (genvar j = 0; j < D; j++) begin : g_lane
    assign sub[j]                  = sub_select($unsigned(j), stage);
    assign twiddle_addr[AW*j +: AW] = twiddle_index($unsigned(j), stage);
  end

endmodule

// File: rtl/intt_flat_ctrl.sv
// Sequencer for the flat D-lane INTT datapath: handshakes, lane register strobes, stage counter.
module intt_flat_ctrl
  import intt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            load,
  output logic            reg_en,
  output logic [SW-1:0]   stage,
  output logic [D-1:0]    sub,
  output logic [D*AW-1:0] twiddle_addr,
  output logic            busy
);

  localparam logic [SW-1:0] STAGE_TOP = SW'(STAGES - 1);

  state_t state;
  logic   accept;
  logic   running;

  // Accepting in HOLD overlaps the result hand-off with the next load, so no IDLE bubble.
  always_comb begin
    in_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
    accept   = in_valid & in_ready & ~rst;
    running  = (state == ST_RUN);
  end

  assign load      = accept;
  assign reg_en    = accept | running;
  assign busy      = accept | running;
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      stage <= STAGE_TOP;
    end else begin
      case (state)
        ST_IDLE: begin
          stage <= STAGE_TOP;
          if (accept) state <= ST_RUN;
        end
        ST_RUN: begin
          if (stage == '0) begin
            state <= ST_HOLD;
            stage <= STAGE_TOP;
          end else begin
            stage <= stage - SW'(1);
          end
        end
        ST_HOLD: begin
          stage <= STAGE_TOP;
          if (out_ready) state <= accept ? ST_RUN : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          stage <= STAGE_TOP;
        end
      endcase
    end
  end

  intt_stage_decode u_decode (
    .stage        (stage),
    .sub          (sub),
    .twiddle_addr (twiddle_addr)
  );

endmodule

// File: tb/tb_intt_flat_ctrl.sv
// Directed plus randomized check of intt_flat_ctrl (D=8) against a timestamp-based reference model.
module tb_intt_flat_ctrl;

  localparam int NL = 8;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        load;
  logic        reg_en;
  logic [1:0]  stage;
  logic [7:0]  sub;
  logic [23:0] twiddle_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a transform accepted in cycle t_acc runs cycles t_acc+1..t_acc+NS,
  // then holds its result until the sink takes it.
  bit pending = 1'b0;
  int t_acc   = -100;
  int cyc     = 0;
  int load_seen = 0;
  int ov_seen   = 0;

  always #5 clk = ~clk;

  intt_flat_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .load         (load),
    .reg_en       (reg_en),
    .stage        (stage),
    .sub          (sub),
    .twiddle_addr (twiddle_addr),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sub(input int s);
    logic [31:0] v;
    int m;
    v = '0;
    for (int j = 0; j < NL; j++) begin
      m = j / (2 ** (NS - 1 - s));
      if (m % 2 == 1) v[j] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_addr(input int s);
    logic [31:0] v;
    int m;
    v = '0;
    for (int j = 0; j < NL; j++) begin
      m = j / (2 ** (NS - 1 - s));
      if (m % 2 == 1) v[3*j +: 3] = 3'((m + 1) / 2 + 2 ** s - 1);
    end
    return v;
  endfunction

  task automatic cyc_step(input bit r, input bit iv, input bit ordy);
    int k;
    int es;
    bit run;
    bit hold;
    bit idle;
    bit rdy;
    bit acc;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    #1;
    k    = cyc - t_acc;
    run  = pending && k >= 1 && k <= NS;
    hold = pending && k > NS;
    idle = !pending;
    es   = run ? NS - k : NS - 1;
    rdy  = idle || (hold && ordy);
    acc  = iv && rdy && !r;
    chk("in_ready",  32'(in_ready),     32'(rdy));
    chk("load",      32'(load),         32'(acc));
    chk("reg_en",    32'(reg_en),       32'(acc || run));
    chk("busy",      32'(busy),         32'(acc || run));
    chk("out_valid", 32'(out_valid),    32'(hold));
    chk("stage",     32'(stage),        32'(es));
    chk("sub",       32'(sub),          exp_sub(es));
    chk("twiddle",   32'(twiddle_addr), exp_addr(es));
    if (load === 1'b1) load_seen++;
    if (out_valid === 1'b1) ov_seen++;
    @(posedge clk);
    if (r) begin
      pending = 1'b0;
    end else begin
      if (hold && ordy) pending = 1'b0;
      if (acc) begin
        pending = 1'b1;
        t_acc   = cyc;
      end
    end
    cyc++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc_step(1, 0, 0);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_stage",     32'(stage),     32'd2);

    // Single transform with decode table
    cyc_step(0, 1, 0);
    #1;
    chk("dec2_stage", 32'(stage),        32'd2);
    chk("dec2_sub",   32'(sub),          32'h0000_00aa);
    chk("dec2_addr",  32'(twiddle_addr), 32'({3'd7, 3'd0, 3'd6, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0}));
    cyc_step(0, 0, 0);
    #1;
    chk("dec1_stage", 32'(stage),        32'd1);
    chk("dec1_sub",   32'(sub),          32'h0000_00cc);
    chk("dec1_addr",  32'(twiddle_addr), 32'({3'd3, 3'd3, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0}));
    cyc_step(0, 0, 0);
    #1;
    chk("dec0_stage", 32'(stage),        32'd0);
    chk("dec0_sub",   32'(sub),          32'h0000_00f0);
    chk("dec0_addr",  32'(twiddle_addr), 32'({3'd1, 3'd1, 3'd1, 3'd1, 12'd0}));
    cyc_step(0, 0, 0);
    #1;
    chk("latency_out_valid", 32'(out_valid), 32'd1);

    // Backpressure then release
    repeat (10) cyc_step(0, 0, 0);
    #1;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_reg_en",    32'(reg_en),    32'd0);
    cyc_step(0, 0, 1);
    #1;
    chk("release_idle_ready", 32'(in_ready), 32'd1);
    chk("release_idle_busy",  32'(busy),     32'd0);

    // Back-to-back: accepts at relative cycles 0,4,8,12
    load_seen = 0;
    repeat (16) cyc_step(0, 1, 1);
    chk("b2b_accepts", 32'(load_seen), 32'd4);
    repeat (5) cyc_step(0, 0, 1);

    // Reset in the middle of a transform
    cyc_step(0, 1, 0);
    cyc_step(0, 0, 0);
    #1;
    chk("pre_rst_stage", 32'(stage), 32'd1);
    ov_seen = 0;
    cyc_step(1, 0, 0);
    #1;
    chk("mid_rst_stage", 32'(stage),    32'd2);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    repeat (6) cyc_step(0, 0, 1);
    chk("mid_rst_no_out_valid", 32'(ov_seen), 32'd0);

    // Randomized traffic
    repeat (400)
      cyc_step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
